// File: rtl/score_accumulator.sv
// score_accumulator: packed-BCD score register with a digit-serial adder.
// Define SCORE_HISCORE_EN to add the hi_score output and its register.
module score_accumulator #(
    parameter logic [11:0] SAT_VALUE = 12'h999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        pts_valid,
    output logic        pts_ready,
    input  logic [3:0]  pts,
    output logic [11:0] score,
    output logic        saturated,
    output logic        score_upd
`ifdef SCORE_HISCORE_EN
    ,
    output logic [11:0] hi_score
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ONES = 2'd1,
        TENS = 2'd2,
        HUND = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic        xfer;

    logic        cap_p1;
    logic [3:0]  cap_p0;
    logic        p1_q;
    logic [3:0]  p0_q;

    logic [3:0]  wk_ones_q;
    logic [3:0]  wk_tens_q;
    logic        c0_q;
    logic        c1_q;

    logic [4:0]  ones_sum;
    logic [4:0]  tens_sum;
    logic [4:0]  hund_sum;
    logic [3:0]  ones_nxt;
    logic [3:0]  tens_nxt;
    logic        c0_nxt;
    logic        c1_nxt;

    logic [11:0] cand;
    logic        sat_hit;
    logic [11:0] commit_val;

    assign pts_ready = (state_q == IDLE) && !clear && rst_n;
    assign xfer      = pts_valid && pts_ready;

    // Split incoming binary points into a tens digit (0/1) and ones digit.
    always_comb begin
        cap_p1 = (pts >= 4'd10);
        cap_p0 = pts;
        if (cap_p1) begin
            cap_p0 = pts - 4'd10;
        end
    end

    // Ones digit: add captured ones with decimal adjust.
    always_comb begin
        ones_sum = {1'b0, score[3:0]} + {1'b0, p0_q};
        c0_nxt   = (ones_sum > 5'd9);
        ones_nxt = ones_sum[3:0];
        if (c0_nxt) begin
            ones_nxt = 4'(ones_sum - 5'd10);
        end
    end

    // Tens digit: add captured tens plus ones carry with decimal adjust.
    always_comb begin
        tens_sum = {1'b0, score[7:4]} + {4'b0, p1_q} + {4'b0, c0_q};
        c1_nxt   = (tens_sum > 5'd9);
        tens_nxt = tens_sum[3:0];
        if (c1_nxt) begin
            tens_nxt = 4'(tens_sum - 5'd10);
        end
    end

    // Hundreds digit and saturation decision for the commit edge.
    always_comb begin
        hund_sum   = {1'b0, score[11:8]} + {4'b0, c1_q};
        cand       = {hund_sum[3:0], wk_tens_q, wk_ones_q};
        sat_hit    = (hund_sum > 5'd9) || (cand > SAT_VALUE);
        commit_val = cand;
        if (sat_hit) begin
            commit_val = SAT_VALUE;
        end
    end

    // Next-state logic; clear returns to IDLE from any state.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (xfer) begin
                        state_d = ONES;
                    end
                end
                ONES: state_d = TENS;
                TENS: state_d = HUND;
                HUND: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture points and run one digit per cycle in the working register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_q      <= 1'b0;
            p0_q      <= 4'd0;
            wk_ones_q <= 4'd0;
            wk_tens_q <= 4'd0;
            c0_q      <= 1'b0;
            c1_q      <= 1'b0;
        end else if (clear) begin
            p1_q      <= 1'b0;
            p0_q      <= 4'd0;
            wk_ones_q <= 4'd0;
            wk_tens_q <= 4'd0;
            c0_q      <= 1'b0;
            c1_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (xfer) begin
                        p1_q <= cap_p1;
                        p0_q <= cap_p0;
                    end
                end
                ONES: begin
                    wk_ones_q <= ones_nxt;
                    c0_q      <= c0_nxt;
                end
                TENS: begin
                    wk_tens_q <= tens_nxt;
                    c1_q      <= c1_nxt;
                end
                HUND: begin
                    c0_q <= 1'b0;
                    c1_q <= 1'b0;
                end
                default: begin
                    c0_q <= 1'b0;
                    c1_q <= 1'b0;
                end
            endcase
        end
    end

    // Visible score only moves on the HUND edge, so no partial digits show.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score     <= 12'h000;
            saturated <= 1'b0;
            score_upd <= 1'b0;
        end else if (clear) begin
            score     <= 12'h000;
            saturated <= 1'b0;
            score_upd <= 1'b0;
        end else begin
            score_upd <= 1'b0;
            if (state_q == HUND) begin
                score     <= commit_val;
                saturated <= saturated | sat_hit;
                score_upd <= 1'b1;
            end
        end
    end

`ifdef SCORE_HISCORE_EN
    // Best committed score; survives clear, only reset zeroes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_score <= 12'h000;
        end else if (!clear && (state_q == HUND)) begin
            if (commit_val > hi_score) begin
                hi_score <= commit_val;
            end
        end
    end
`endif

endmodule

// File: tb/tb_score_accumulator.sv
// tb_score_accumulator: scoreboard bench with a decimal reference model.
// Driver predicts commits; a monitor pops them when score_upd fires.
module tb_score_accumulator;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        pts_valid;
    logic        pts_ready;
    logic [3:0]  pts;
    logic [11:0] score;
    logic        saturated;
    logic        score_upd;
`ifdef SCORE_HISCORE_EN
    logic [11:0] hi_score;
`endif

    score_accumulator #(
        .SAT_VALUE(12'h999)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .pts_valid(pts_valid),
        .pts_ready(pts_ready),
        .pts      (pts),
        .score    (score),
        .saturated(saturated),
        .score_upd(score_upd)
`ifdef SCORE_HISCORE_EN
        ,
        .hi_score (hi_score)
`endif
    );

    typedef struct {
        logic [11:0] s;
        logic        sat;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          checks;
    int          failures;
    int          cyc;
    int          busy;
    int          m_int;
    logic        m_sat;
    logic [11:0] vis_score;
    logic        vis_sat;
    logic [11:0] vis_hi;
    int          upd_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at cyc %0d",
                     name, act, exp, cyc);
        end
    endtask

    // One clock of stimulus plus the reference model update on its edge.
    task automatic step(input logic c, input logic v, input logic [3:0] p);
        logic exp_ready;
        logic xfer;
        int   t;
        @(negedge clk);
        clear     = c;
        pts_valid = v;
        pts       = p;
        #1;
        exp_ready = rst_n && (busy == 0) && !c;
        chk("pts_ready", pts_ready, exp_ready);
        xfer = v && exp_ready;
        @(posedge clk);
        cyc++;
        if (rst_n && c) begin
            q.delete();
            busy      = 0;
            m_int     = 0;
            m_sat     = 1'b0;
            vis_score = 12'h000;
            vis_sat   = 1'b0;
        end else if (xfer) begin
            t = m_int + int'(p);
            if (t > 999) begin
                t     = 999;
                m_sat = 1'b1;
            end
            m_int = t;
            q.push_back('{s: to_bcd(t), sat: m_sat, due: cyc + 3});
            busy = 3;
        end else if (busy > 0) begin
            busy--;
        end
    endtask

    task automatic add(input logic [3:0] p);
        while (busy > 0) step(1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b1, p);
        repeat (3) step(1'b0, 1'b0, 4'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n     = 1'b0;
        clear     = 1'b0;
        pts_valid = 1'b0;
        pts       = 4'd0;
        #1;
        chk("rst_score", score, 12'h000);
        chk("rst_saturated", saturated, 1'b0);
        chk("rst_score_upd", score_upd, 1'b0);
        chk("rst_pts_ready", pts_ready, 1'b0);
`ifdef SCORE_HISCORE_EN
        chk("rst_hi_score", hi_score, 12'h000);
`endif
        q.delete();
        busy      = 0;
        m_int     = 0;
        m_sat     = 1'b0;
        vis_score = 12'h000;
        vis_sat   = 1'b0;
        vis_hi    = 12'h000;
        step(1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 4'd0);
        #3 rst_n = 1'b1;
    endtask

    // Monitor: pops an expectation whenever a commit is due.
    initial begin
        exp_t e;
        logic due_now;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                due_now = (q.size() > 0) && (q[0].due <= cyc);
                chk("score_upd", score_upd, due_now);
                if (score_upd) upd_cnt++;
                if (due_now) begin
                    e         = q.pop_front();
                    vis_score = e.s;
                    vis_sat   = e.sat;
                    if (e.s > vis_hi) vis_hi = e.s;
                end
                chk("score", score, vis_score);
                chk("saturated", saturated, vis_sat);
`ifdef SCORE_HISCORE_EN
                chk("hi_score", hi_score, vis_hi);
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int u;
        logic c;
        logic v;
        logic [3:0] p;
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        busy      = 0;
        m_int     = 0;
        m_sat     = 1'b0;
        vis_score = 12'h000;
        vis_sat   = 1'b0;
        vis_hi    = 12'h000;
        upd_cnt   = 0;
        rst_n     = 1'b0;
        clear     = 1'b0;
        pts_valid = 1'b0;
        pts       = 4'd0;

        do_reset();

        u = upd_cnt;
        step(1'b0, 1'b1, 4'd7);
        repeat (3) step(1'b0, 1'b0, 4'd0);
        #2;
        chk("t7_score", score, 12'h007);
        chk("t7_pulses", upd_cnt - u, 1);

        u = upd_cnt;
        add(4'd0);
        #2;
        chk("zero_score", score, 12'h007);
        chk("zero_pulses", upd_cnt - u, 1);

        u = upd_cnt;
        step(1'b1, 1'b1, 4'd5);
        repeat (3) step(1'b0, 1'b0, 4'd0);
        #2;
        chk("clr_valid_score", score, 12'h000);
        chk("clr_valid_pulses", upd_cnt - u, 0);

        repeat (6) add(4'd15);
        add(4'd5);
        #2;
        chk("pre95_score", score, 12'h095);
        add(4'd15);
        #2;
        chk("carry_score", score, 12'h110);
        chk("carry_sat", saturated, 1'b0);

        step(1'b1, 1'b0, 4'd0);
        add(4'd10);
        add(4'd10);
        #2;
        chk("pre20_score", score, 12'h020);
        u = upd_cnt;
        step(1'b0, 1'b1, 4'd5);
        step(1'b0, 1'b0, 4'd0);
        step(1'b1, 1'b0, 4'd0);
        #2;
        chk("tens_clr_score", score, 12'h000);
        step(1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 4'd0);
        chk("tens_clr_pulses", upd_cnt - u, 0);

        u = upd_cnt;
        repeat (16) step(1'b0, 1'b1, 4'd3);
        repeat (2) step(1'b0, 1'b0, 4'd0);
        #2;
        chk("stream_score", score, 12'h012);
        chk("stream_pulses", upd_cnt - u, 4);

`ifdef SCORE_HISCORE_EN
        do_reset();
        repeat (3) add(4'd15);
        add(4'd5);
        step(1'b1, 1'b0, 4'd0);
        add(4'd5);
        #2;
        chk("hi_cur_score", score, 12'h005);
        chk("hi_kept", hi_score, 12'h050);
        do_reset();
        #2;
        chk("hi_after_rst", hi_score, 12'h000);
`endif

        step(1'b1, 1'b0, 4'd0);
        repeat (66) add(4'd15);
        add(4'd5);
        #2;
        chk("pre995_score", score, 12'h995);
        add(4'd9);
        #2;
        chk("sat_score", score, 12'h999);
        chk("sat_flag", saturated, 1'b1);
        u = upd_cnt;
        add(4'd1);
        #2;
        chk("sat_hold_score", score, 12'h999);
        chk("sat_hold_flag", saturated, 1'b1);
        chk("sat_hold_pulses", upd_cnt - u, 1);

        add(4'd0);
        step(1'b0, 1'b1, 4'd9);
        step(1'b0, 1'b0, 4'd0);
        do_reset();
        step(1'b0, 1'b0, 4'd0);
        repeat (4) step(1'b0, 1'b0, 4'd0);
        #2;
        chk("midrst_score", score, 12'h000);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end
            c = ($urandom_range(0, 79) == 0);
            v = ($urandom_range(0, 3) != 0);
            p = 4'($urandom_range(0, 15));
            step(c, v, p);
        end
        repeat (5) step(1'b0, 1'b0, 4'd0);
        #2;
        chk("end_score", score, to_bcd(m_int));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/score_accumulator.md
SCORE_ACCUMULATOR -- requirements
Module: score_accumulator

Interface
REQ-001 SHALL have parameter SAT_VALUE, default 12'h999, packed-BCD saturation ceiling {hund,tens,ones}.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clear  input  1  synchronous score clear, active-high.
REQ-005 SHALL have port pts_valid  input  1  points offer valid.
REQ-006 SHALL have port pts_ready  output  1  accumulator can accept points.
REQ-007 SHALL have port pts  input  4  binary points, 0–15.
REQ-008 SHALL have port score  output  12  packed BCD {hund[11:8],tens[7:4],ones[3:0]}, feeds the score display stage directly.
REQ-009 SHALL have port saturated  output  1  sticky overflow flag.
REQ-010 SHALL have port score_upd  output  1  one-cycle pulse marking a committed addition.

Function
REQ-011 Transfer SHALL occur on a rising edge where pts_valid && pts_ready && !clear; pts is captured on that edge.
REQ-012 pts_ready SHALL be combinational: state==IDLE && !clear && rst_n.
REQ-013 FSM SHALL have states IDLE -> ONES -> TENS -> HUND -> IDLE, one edge each; IDLE->ONES only on transfer.
REQ-014 On capture, pts SHALL be split into BCD digits p1 = (pts>=10), p0 = pts-10*p1.
REQ-015 ONES SHALL compute work_ones = ones+p0 with decimal adjust (>9: subtract 10, c0=1).
REQ-016 TENS SHALL compute work_tens = tens+p1+c0 with decimal adjust, carry c1.
REQ-017 HUND SHALL compute hund+c1; if the result exceeds 9 or the full BCD value exceeds SAT_VALUE, the committed value SHALL be SAT_VALUE and saturated SHALL set.
REQ-018 Digit math SHALL use a working register; score SHALL change only at the HUND edge (commit), never showing partial digits.
REQ-019 Latency: transfer at edge N -> new score and score_upd=1 after edge N+3; score_upd low all other cycles; pts_ready high again after edge N+3.
REQ-020 Throughput SHALL be one transfer per 4 cycles maximum.
REQ-021 pts=0 SHALL run the full sequence, pulse score_upd, leave score unchanged.
REQ-022 When saturated=1, transfers SHALL still be accepted and pulse score_upd; score stays SAT_VALUE.
REQ-023 saturated SHALL remain 1 until clear or reset.
REQ-024 clear SHALL have top priority in every state: next edge forces IDLE, score=12'h000, saturated=0, discards in-flight addition, no score_upd.
REQ-025 clear and pts_valid in same cycle SHALL result in no transfer.

Reset
REQ-026 rst_n low SHALL immediately force: state=IDLE, score=12'h000, saturated=0, score_upd=0, working register=0, pts_ready=0.
REQ-027 Reset mid-sequence SHALL abandon the addition with no commit.
REQ-028 First transfer SHALL be possible on the first edge after rst_n deasserts.

Configuration
REQ-029 Macro SCORE_HISCORE_EN defined SHALL add output port hi_score (12, packed BCD), reset to 12'h000.
REQ-030 With SCORE_HISCORE_EN, at each commit, if committed score > hi_score (unsigned packed compare), hi_score SHALL take it on the same edge.
REQ-031 With SCORE_HISCORE_EN, hi_score SHALL be unaffected by clear; only rst_n zeroes it.
REQ-032 Without SCORE_HISCORE_EN, port hi_score and its register SHALL not exist; all other behaviour identical.

Verification
REQ-033 Reset, offer pts=7 -> score 12'h007 three edges after transfer, single score_upd pulse, pts_ready low for 3 cycles.
REQ-034 score 12'h095, pts=15 -> score 12'h110 (ones carry, tens carry), saturated=0.
REQ-035 score 12'h995, pts=9 -> score 12'h999, saturated=1; further pts=1 -> 12'h999, score_upd pulses.
REQ-036 clear asserted while in TENS after a pts=5 transfer from 12'h020 -> score 12'h000, no score_upd, pts_ready=1 next cycle.
REQ-037 pts_valid held high with pts=3 for 16 cycles from 12'h000 -> exactly 4 transfers, score 12'h012.
REQ-038 SCORE_HISCORE_EN: reach 12'h050, clear, add pts=5 -> score 12'h005, hi_score 12'h050; rst_n -> hi_score 12'h000.
